dmac_write_cmd_arb: RTL and testbench

Shares the single write request generator between CHANNEL_COUNT DMA channels. Round-robin arbitrates the per-channel write commands and presents the winner on a registered cmd_out handshake to the generator's command input. Records the issuing channel ID in an in-order tracking FIFO. Routes per-command write completions back to the owning channel as a one-cycle done pulse.

---
 rtl/dmac_pkg.sv | 22 ++
 rtl/dmac_id_fifo.sv | 52 +++++
 rtl/dmac_write_cmd_arb.sv | 162 ++++++++++++++++
 tb/tb_dmac_write_cmd_arb.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared DMA controller types: the write command descriptor and arbiter FSM states.
package dmac_pkg;

    localparam int ADDR_WD    = 32;
    localparam int BURST_BITS = 2;
    localparam int SIZE_BITS  = 3;
    localparam int OFS_WD     = $clog2(ADDR_WD / 8);

    typedef struct packed {
        logic [ADDR_WD-1:0]    dst_addr;
        logic [ADDR_WD-1:0]    len;
        logic [BURST_BITS-1:0] burst;
        logic [SIZE_BITS-1:0]  size;
        logic [OFS_WD-1:0]     src_offset;
    } dmac_wr_cmd_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmac_id_fifo.sv
// Small synchronous FIFO holding the channel IDs of issued, uncompleted commands.
module dmac_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WD    = 3,
    localparam int PTR_WD = $clog2(DEPTH),
    localparam int CNT_WD = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WD-1:0]     push_data_i,
    input  logic              pop_i,
    output logic [WD-1:0]     head_o,
    output logic [CNT_WD-1:0] count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [WD-1:0]     mem_q [DEPTH];
    logic [PTR_WD-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_WD-1:0] count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CNT_WD'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmac_write_cmd_arb.sv
// Round-robin arbiter sharing one write request generator among DMA channels,
// with in-order completion routing back to the issuing channel.
module dmac_write_cmd_arb #(
    parameter int ADDR_WD         = 32,
    parameter int CHANNEL_COUNT   = 8,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CH_ID_WD = $clog2(CHANNEL_COUNT),
    localparam int OFS_WD   = $clog2(ADDR_WD / 8),
    localparam int CNT_WD   = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [CHANNEL_COUNT-1:0]                         ch_cmd_valid_i,
    output logic [CHANNEL_COUNT-1:0]                         ch_cmd_ready_o,
    input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]            ch_cmd_dst_addr_i,
    input  logic [CHANNEL_COUNT-1:0][ADDR_WD-1:0]            ch_cmd_len_i,
    input  logic [CHANNEL_COUNT-1:0][dmac_pkg::BURST_BITS-1:0] ch_cmd_burst_i,
    input  logic [CHANNEL_COUNT-1:0][dmac_pkg::SIZE_BITS-1:0]  ch_cmd_size_i,
    input  logic [CHANNEL_COUNT-1:0][OFS_WD-1:0]             ch_cmd_src_offset_i,
    output logic                                             cmd_out_valid_o,
    input  logic                                             cmd_out_ready_i,
    output logic [ADDR_WD-1:0]                               cmd_out_dst_addr_o,
    output logic [ADDR_WD-1:0]                               cmd_out_len_o,
    output logic [dmac_pkg::BURST_BITS-1:0]                  cmd_out_burst_o,
    output logic [dmac_pkg::SIZE_BITS-1:0]                   cmd_out_size_o,
    output logic [OFS_WD-1:0]                                cmd_out_src_offset_o,
    output logic [CH_ID_WD-1:0]                              cmd_out_ch_id_o,
    input  logic                                             wr_done_valid_i,
    input  logic                                             wr_done_err_i,
    output logic [CHANNEL_COUNT-1:0]                         ch_done_o,
    output logic                                             ch_done_err_o,
    output logic [CNT_WD-1:0]                                outstanding_o,
    output logic                                             underflow_err_o
);

    import dmac_pkg::*;

    typedef struct packed {
        logic [ADDR_WD-1:0]    dst_addr;
        logic [ADDR_WD-1:0]    len;
        logic [BURST_BITS-1:0] burst;
        logic [SIZE_BITS-1:0]  size;
        logic [OFS_WD-1:0]     src_offset;
    } cmd_t;

    arb_state_e         state_q;
    logic               cmd_valid_q;
    cmd_t               cmd_q, cmd_d;
    logic [CH_ID_WD-1:0] id_q;
    logic [CH_ID_WD-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_ID_WD-1:0] win_idx;
    logic               win_found;
    logic               grant;

    logic               push, pop;
    logic [CH_ID_WD-1:0] fifo_head;
    logic               fifo_full, fifo_empty;

    logic [CHANNEL_COUNT-1:0] ch_done_q;
    logic                     ch_done_err_q;
    logic                     underflow_q;

    // First valid channel at or after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (!win_found && ch_cmd_valid_i[(int'(rr_ptr_q) + i) % CHANNEL_COUNT]) begin
                win_found = 1'b1;
                win_idx   = CH_ID_WD'((int'(rr_ptr_q) + i) % CHANNEL_COUNT);
            end
        end
    end

    // Grant depends only on registered state and channel inputs, never on cmd_out_ready_i.
    assign grant          = !rst && (state_q == ARB_IDLE) && win_found && !fifo_full;
    assign ch_cmd_ready_o = grant ? (CHANNEL_COUNT'(1) << win_idx) : '0;

    assign rr_ptr_d = (win_idx == CH_ID_WD'(CHANNEL_COUNT - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        cmd_d            = '0;
        cmd_d.dst_addr   = ch_cmd_dst_addr_i[win_idx];
        cmd_d.len        = ch_cmd_len_i[win_idx];
        cmd_d.burst      = ch_cmd_burst_i[win_idx];
        cmd_d.size       = ch_cmd_size_i[win_idx];
        cmd_d.src_offset = ch_cmd_src_offset_i[win_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            id_q        <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        cmd_q       <= cmd_d;
                        id_q        <= win_idx;
                        cmd_valid_q <= 1'b1;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (cmd_out_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign cmd_out_valid_o      = cmd_valid_q;
    assign cmd_out_dst_addr_o   = cmd_q.dst_addr;
    assign cmd_out_len_o        = cmd_q.len;
    assign cmd_out_burst_o      = cmd_q.burst;
    assign cmd_out_size_o       = cmd_q.size;
    assign cmd_out_src_offset_o = cmd_q.src_offset;
    assign cmd_out_ch_id_o      = id_q;

    // Grant requires space and only one command is in flight, so this push cannot overflow.
    assign push = (state_q == ARB_ISSUE) && cmd_out_ready_i;
    assign pop  = wr_done_valid_i && !fifo_empty;

    dmac_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WD    (CH_ID_WD)
    ) u_id_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (id_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (outstanding_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_done_q     <= '0;
            ch_done_err_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            ch_done_q     <= pop ? (CHANNEL_COUNT'(1) << fifo_head) : '0;
            ch_done_err_q <= pop && wr_done_err_i;
            if (wr_done_valid_i && fifo_empty) underflow_q <= 1'b1;
        end
    end

    assign ch_done_o       = ch_done_q;
    assign ch_done_err_o   = ch_done_err_q;
    assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_dmac_write_cmd_arb.sv
// Scoreboard bench for dmac_write_cmd_arb: expected commands and completions are
// queued as stimulus is driven and compared as the DUT produces them.
module tb_dmac_write_cmd_arb;

    import dmac_pkg::*;

    typedef struct packed {
        logic [2:0]   id;
        dmac_wr_cmd_t cmd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        ch_cmd_valid;
    logic [7:0]        ch_cmd_ready;
    logic [7:0][31:0]  ch_dst, ch_len;
    logic [7:0][1:0]   ch_burst;
    logic [7:0][2:0]   ch_size;
    logic [7:0][1:0]   ch_ofs;
    logic              cmd_out_valid, cmd_out_ready;
    logic [31:0]       out_dst, out_len;
    logic [1:0]        out_burst;
    logic [2:0]        out_size;
    logic [1:0]        out_ofs;
    logic [2:0]        out_id;
    logic              wr_done_valid, wr_done_err;
    logic [7:0]        ch_done;
    logic              ch_done_err;
    logic [2:0]        outstanding;
    logic              underflow_err;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   auto_done = 1'b0;

    exp_t       exp_cmd_q[$];
    logic [2:0] exp_id_q[$];
    logic [7:0] exp_done_vec = '0;
    logic       exp_done_err = 1'b0;
    logic       exp_uf = 1'b0;

    always #5 clk = ~clk;

    dmac_write_cmd_arb dut (
        .clk                  (clk),
        .rst                  (rst),
        .ch_cmd_valid_i       (ch_cmd_valid),
        .ch_cmd_ready_o       (ch_cmd_ready),
        .ch_cmd_dst_addr_i    (ch_dst),
        .ch_cmd_len_i         (ch_len),
        .ch_cmd_burst_i       (ch_burst),
        .ch_cmd_size_i        (ch_size),
        .ch_cmd_src_offset_i  (ch_ofs),
        .cmd_out_valid_o      (cmd_out_valid),
        .cmd_out_ready_i      (cmd_out_ready),
        .cmd_out_dst_addr_o   (out_dst),
        .cmd_out_len_o        (out_len),
        .cmd_out_burst_o      (out_burst),
        .cmd_out_size_o       (out_size),
        .cmd_out_src_offset_o (out_ofs),
        .cmd_out_ch_id_o      (out_id),
        .wr_done_valid_i      (wr_done_valid),
        .wr_done_err_i        (wr_done_err),
        .ch_done_o            (ch_done),
        .ch_done_err_o        (ch_done_err),
        .outstanding_o        (outstanding),
        .underflow_err_o      (underflow_err)
    );

    function automatic exp_t mk_exp(input int ch);
        exp_t e;
        e.id             = 3'(ch);
        e.cmd.dst_addr   = ch_dst[ch];
        e.cmd.len        = ch_len[ch];
        e.cmd.burst      = ch_burst[ch];
        e.cmd.size       = ch_size[ch];
        e.cmd.src_offset = ch_ofs[ch];
        return e;
    endfunction

    // Monitor: compares completion pulses, occupancy, sticky underflow and issued
    // commands against the bench model, then advances the model for the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t       e, got;
            logic [7:0] nxt_vec;
            logic       nxt_err;
            checks++;
            if (outstanding !== 3'(exp_id_q.size())) begin
                errors++;
                $display("FAIL outstanding: got %0d expected %0d", outstanding, exp_id_q.size());
            end
            checks++;
            if (ch_done !== exp_done_vec || ch_done_err !== exp_done_err) begin
                errors++;
                $display("FAIL ch_done: got %b/%b expected %b/%b", ch_done, ch_done_err, exp_done_vec, exp_done_err);
            end
            checks++;
            if (underflow_err !== exp_uf) begin
                errors++;
                $display("FAIL underflow_err: got %b expected %b", underflow_err, exp_uf);
            end
            nxt_vec = '0;
            nxt_err = 1'b0;
            if (rst) begin
                exp_id_q.delete();
                exp_uf = 1'b0;
            end else begin
                if (wr_done_valid) begin
                    if (exp_id_q.size() != 0) begin
                        nxt_vec = 8'd1 << exp_id_q.pop_front();
                        nxt_err = wr_done_err;
                    end else begin
                        exp_uf = 1'b1;
                    end
                end
                if (cmd_out_valid && cmd_out_ready) begin
                    checks++;
                    if (exp_cmd_q.size() == 0) begin
                        errors++;
                        $display("FAIL cmd_out: unexpected handshake id %0d", out_id);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        got = {out_id, out_dst, out_len, out_burst, out_size, out_ofs};
                        if (got !== e) begin
                            errors++;
                            $display("FAIL cmd_out: got %h expected %h", got, e);
                        end
                        exp_id_q.push_back(e.id);
                    end
                end
            end
            exp_done_vec = nxt_vec;
            exp_done_err = nxt_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_done) wr_done_valid = (exp_id_q.size() != 0);
    endtask

    // Wait (bounded) for any ch_cmd_ready; it must be exactly the expected channel.
    task automatic await_grant(input int ch, input int budget);
        bit got = 1'b0;
        logic [7:0] want;
        want = 8'd1 << ch;
        for (int c = 0; c < budget && !got; c++) begin
            #1;
            if (ch_cmd_ready !== 8'd0) begin
                checks++;
                if (ch_cmd_ready !== want) begin
                    errors++;
                    $display("FAIL grant: got %b expected %b", ch_cmd_ready, want);
                end
                exp_cmd_q.push_back(mk_exp(ch));
                got = 1'b1;
            end else begin
                tick();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant: timeout waiting for channel %0d", ch);
        end
    endtask

    task automatic issue_one(input int ch);
        ch_cmd_valid[ch] = 1'b1;
        await_grant(ch, 4);
        tick();
        ch_cmd_valid[ch] = 1'b0;
        tick();
    endtask

    task automatic drain();
        auto_done = 1'b1;
        wr_done_valid = (exp_id_q.size() != 0);
        for (int c = 0; c < 30 && exp_id_q.size() != 0; c++) tick();
        auto_done = 1'b0;
        wr_done_valid = 1'b0;
        checks++;
        if (exp_id_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left", exp_id_q.size());
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_cmd_valid = 8'hFF;
        tick();
        tick();
        checks++;
        if (ch_cmd_ready !== 8'd0 || cmd_out_valid !== 1'b0 || ch_done !== 8'd0 ||
            outstanding !== 3'd0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b vld=%b done=%b out=%0d uf=%b", ch_cmd_ready,
                     cmd_out_valid, ch_done, outstanding, underflow_err);
        end
        mon_en = 1'b1;
        ch_cmd_valid = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 3, 7, 0, 3, 7};
        cmd_out_ready = 1'b1;
        auto_done = 1'b1;
        ch_cmd_valid = 8'b1000_1001;
        foreach (order[k]) begin
            await_grant(order[k], 6);
            tick();
        end
        ch_cmd_valid = '0;
        tick();
        drain();
    endtask

    task automatic test_single();
        ch_dst[2] = 32'h0000_1000;
        ch_len[2] = 32'd64;
        cmd_out_ready = 1'b0;
        ch_cmd_valid[2] = 1'b1;
        await_grant(2, 1);
        tick();
        ch_cmd_valid[2] = 1'b0;
        checks++;
        if (cmd_out_valid !== 1'b1 || out_id !== 3'd2 || out_dst !== 32'h1000 || out_len !== 32'd64) begin
            errors++;
            $display("FAIL single: vld=%b id=%0d dst=%h len=%0d", cmd_out_valid, out_id, out_dst, out_len);
        end
        cmd_out_ready = 1'b1;
        tick();
        checks++;
        if (outstanding !== 3'd1 || cmd_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_out: outstanding=%0d vld=%b expected 1/0", outstanding, cmd_out_valid);
        end
        wr_done_valid = 1'b1;
        tick();
        wr_done_valid = 1'b0;
        checks++;
        if (ch_done !== 8'b0000_0100) begin
            errors++;
            $display("FAIL single_done: got %b expected 00000100", ch_done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        cmd_out_ready = 1'b0;
        ch_cmd_valid[1] = 1'b1;
        await_grant(1, 1);
        tick();
        ch_cmd_valid[1] = 1'b0;
        ch_cmd_valid[4] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (cmd_out_valid !== 1'b1 || out_id !== 3'd1 || out_dst !== ch_dst[1] ||
                out_len !== ch_len[1] || ch_cmd_ready !== 8'd0) begin
                errors++;
                $display("FAIL backpressure: vld=%b id=%0d dst=%h ready=%b", cmd_out_valid, out_id,
                         out_dst, ch_cmd_ready);
            end
            tick();
        end
        cmd_out_ready = 1'b1;
        tick();
        checks++;
        if (outstanding !== 3'd1) begin
            errors++;
            $display("FAIL backpressure_push: outstanding=%0d expected 1", outstanding);
        end
        await_grant(4, 1);
        tick();
        ch_cmd_valid[4] = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_full_stall();
        int chs[4] = '{5, 6, 1, 2};
        cmd_out_ready = 1'b1;
        foreach (chs[k]) issue_one(chs[k]);
        ch_cmd_valid[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ch_cmd_ready !== 8'd0 || outstanding !== 3'd4) begin
                errors++;
                $display("FAIL full_stall: ready=%b outstanding=%0d expected 0/4", ch_cmd_ready, outstanding);
            end
            tick();
        end
        wr_done_valid = 1'b1;
        tick();
        wr_done_valid = 1'b0;
        await_grant(0, 1);
        tick();
        ch_cmd_valid[0] = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_underflow_err();
        checks++;
        if (underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pre: got %b expected 0", underflow_err);
        end
        wr_done_valid = 1'b1;
        tick();
        wr_done_valid = 1'b0;
        checks++;
        if (underflow_err !== 1'b1 || ch_done !== 8'd0) begin
            errors++;
            $display("FAIL underflow: uf=%b done=%b expected 1/00000000", underflow_err, ch_done);
        end
        cmd_out_ready = 1'b1;
        issue_one(3);
        wr_done_valid = 1'b1;
        wr_done_err = 1'b1;
        tick();
        wr_done_valid = 1'b0;
        wr_done_err = 1'b0;
        checks++;
        if (ch_done !== 8'b0000_1000 || ch_done_err !== 1'b1) begin
            errors++;
            $display("FAIL done_err: done=%b err=%b expected 00001000/1", ch_done, ch_done_err);
        end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        cmd_out_ready = 1'b1;
        issue_one(1);
        issue_one(6);
        cmd_out_ready = 1'b0;
        ch_cmd_valid[4] = 1'b1;
        await_grant(4, 1);
        tick();
        ch_cmd_valid[4] = 1'b0;
        checks++;
        if (cmd_out_valid !== 1'b1 || outstanding !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset: vld=%b outstanding=%0d expected 1/2", cmd_out_valid, outstanding);
        end
        rst = 1'b1;
        exp_cmd_q.delete();
        tick();
        rst = 1'b0;
        checks++;
        if (cmd_out_valid !== 1'b0 || outstanding !== 3'd0 || ch_done !== 8'd0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: vld=%b out=%0d done=%b uf=%b expected 0/0/0/0", cmd_out_valid,
                     outstanding, ch_done, underflow_err);
        end
        cmd_out_ready = 1'b1;
        ch_cmd_valid = 8'b0010_0001;
        await_grant(0, 1);
        tick();
        ch_cmd_valid = '0;
        tick();
        drain();
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin
            ch_dst[c]   = 32'h1000_0000 + 32'(c) * 32'h100;
            ch_len[c]   = 32'd16 * 32'(c + 1);
            ch_burst[c] = 2'(c % 3);
            ch_size[c]  = 3'(c);
            ch_ofs[c]   = 2'(c);
        end
        cmd_out_ready = 1'b0;
        wr_done_valid = 1'b0;
        wr_done_err   = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_full_stall();
        test_underflow_err();
        test_reset_mid_issue();
        checks++;
        if (exp_cmd_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected commands never issued", exp_cmd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
